// File: rtl/ahb_sram_slave_pkg.sv
// Package for the AHB SRAM slave.
// Holds the AHB bus codes, the slave FSM state type and the address legality helper.
// The bus codes are the same values as the shared ahb_macro_h.v header. They are
// guarded so that they coexist with that header when both are in one build.
// Optional feature: AHB_SLV_ERR_RESP_EN (used by ahb_sram_slave.sv).

`ifndef AHB_MACRO_H_V
`define AHB_MACRO_H_V
`define IDLE     2'b00
`define BUSY     2'b01
`define NONSEQ   2'b10
`define SEQ      2'b11
`define AHB_BYTE 3'b000
`define AHB_HALF 3'b001
`define AHB_WORD 3'b010
`define SINGLE   3'b000
`define INCR     3'b001
`define INCR4    3'b011
`define INCR8    3'b101
`define INCR16   3'b111
`endif

`ifndef OKAY
`define OKAY  2'b00
`endif
`ifndef ERROR
`define ERROR 2'b01
`endif

package ahb_sram_slave_pkg;

    // Data-phase state of the slave. Exposed on s_dbg_state.
    typedef enum logic [2:0] {
        SL_IDLE = 3'd0,
        SL_WAIT = 3'd1,
        SL_DATA = 3'd2,
        SL_ERR1 = 3'd3,
        SL_ERR2 = 3'd4
    } sl_state_e;

    // A transfer is legal when it is a word access, word aligned, and inside
    // [base, base + 4*depth). The span is 33 bits wide so that the top of the
    // window cannot wrap.
    function automatic logic addr_legal(input logic [31:0]  addr,
                                        input logic [31:0]  base,
                                        input logic [2:0]   size,
                                        input int unsigned  depth);
        logic [31:0] offset;
        logic [32:0] span;
        offset = addr - base;
        span   = 33'(depth) << 2;
        return (addr >= base) && ({1'b0, offset} < span) &&
               (addr[1:0] == 2'b00) && (size == `AHB_WORD);
    endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// Single-port word RAM behind the AHB SRAM slave.
// The write is synchronous. The read is asynchronous, by the same index.
// Contents are not reset.
// Ports:
//   clk    in   clock
//   we     in   write enable; mem[idx] <= wdata at the rising edge
//   idx    in   word index, $clog2(MEM_DEPTH) bits
//   wdata  in   32-bit write data
//   rdata  out  32-bit read data, mem[idx]

module ahb_slv_mem #(
    parameter  int MEM_DEPTH = 256,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_array [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[idx] <= wdata;
        end
    end

    assign rdata = mem_array[idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave that fronts a word-wide on-chip SRAM and accepts pipelined word transfers.
// Each data phase gets WAIT_CYCLES wait states. Illegal transfers are: out of range,
// misaligned, or not word sized.
// Optional feature: AHB_SLV_ERR_RESP_EN.
//   Defined:   an illegal transfer gets the two-cycle ERROR response.
//   Undefined: HRESP is always OKAY. An illegal read returns 0 and an illegal write is
//              discarded, with the same timing as a legal access.
// Ports:
//   s_HCLK, s_HRESET            clock; synchronous active-high reset
//   s_HSEL, s_HADDR, s_HTRANS,  address-phase inputs
//   s_HWRITE, s_HSIZE, s_HBURST
//   s_HWDATA                    data-phase write data
//   s_HREADY                    bus ready (previous transfer complete)
//   s_HREADYOUT, s_HRESP        this slave's ready and response (registered)
//   s_HRDATA                    read data; 0 outside a read data phase
//   s_dbg_state                 current FSM state, for observation
// Handshake: an address phase is accepted at a rising edge where
// s_HSEL & s_HTRANS[1] & s_HREADY. Its data phase completes at the first later edge
// where s_HREADYOUT is 1.

module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        s_HCLK,
    input  logic        s_HRESET,
    input  logic        s_HSEL,
    input  logic [31:0] s_HADDR,
    input  logic [1:0]  s_HTRANS,
    input  logic        s_HWRITE,
    input  logic [2:0]  s_HSIZE,
    input  logic [2:0]  s_HBURST,
    input  logic [31:0] s_HWDATA,
    input  logic        s_HREADY,
    output logic        s_HREADYOUT,
    output logic [1:0]  s_HRESP,
    output logic [31:0] s_HRDATA,
    output logic [2:0]  s_dbg_state
);

    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [2:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    sl_state_e     state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic          legal_q, legal_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          hreadyout_q, hreadyout_d;
    logic [1:0]    hresp_q, hresp_d;

    logic          capture;
    logic          cap_legal;
    logic [31:0]   offset;
    logic [31:0]   mem_rdata;
    logic          mem_we;
    logic          unused_bits;

    assign offset    = s_HADDR - BASE_ADDR;
    assign cap_legal = addr_legal(s_HADDR, BASE_ADDR, s_HSIZE, MEM_DEPTH);

    // HBURST carries no information here: the master supplies every beat's address.
    assign unused_bits = ^{s_HBURST, offset[31:AW+2], offset[1:0]};

    // Addresses are only taken while no wait or ERR1 cycle is stalling the bus.
    // s_HREADY is low in those states anyway. Gating on state also covers a
    // mux that does not loop HREADYOUT back.
    always_comb begin
        capture = s_HSEL & s_HTRANS[1] & s_HREADY &
                  (state_q inside {SL_IDLE, SL_DATA, SL_ERR2});
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        write_d = write_q;
        legal_d = legal_q;
        cnt_d   = cnt_q;

        case (state_q)
            SL_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = SL_DATA;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            SL_ERR1: state_d = SL_ERR2;
            // IDLE, DATA and ERR2 fall back to IDLE unless a new transfer chains in.
            default: state_d = SL_IDLE;
        endcase

        if (capture) begin
            idx_d   = offset[AW+1:2];
            write_d = s_HWRITE;
            legal_d = cap_legal;
            cnt_d   = WAIT_INIT;
`ifdef AHB_SLV_ERR_RESP_EN
            if (!cap_legal) begin
                state_d = SL_ERR1;
            end else begin
                state_d = (WAIT_CYCLES > 0) ? SL_WAIT : SL_DATA;
            end
`else
            state_d = (WAIT_CYCLES > 0) ? SL_WAIT : SL_DATA;
`endif
        end

        // Outputs are registered, so they are decoded from the next state.
        hreadyout_d = !(state_d inside {SL_WAIT, SL_ERR1});
`ifdef AHB_SLV_ERR_RESP_EN
        hresp_d = (state_d inside {SL_ERR1, SL_ERR2}) ? `ERROR : `OKAY;
`else
        hresp_d = `OKAY;
`endif
    end

    always_ff @(posedge s_HCLK) begin
        if (s_HRESET) begin
            state_q     <= SL_IDLE;
            idx_q       <= '0;
            write_q     <= 1'b0;
            legal_q     <= 1'b0;
            cnt_q       <= 3'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= `OKAY;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            write_q     <= write_d;
            legal_q     <= legal_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // HREADYOUT is always 1 in SL_DATA, so the write completes at this edge.
    // A reset edge drops the pending write.
    assign mem_we = (state_q == SL_DATA) & write_q & legal_q & ~s_HRESET;

    ahb_slv_mem #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (s_HCLK),
        .we    (mem_we),
        .idx   (idx_q),
        .wdata (s_HWDATA),
        .rdata (mem_rdata)
    );

    // Read data comes straight from the asynchronous RAM port, not from a flop.
    // A read captured at the same edge as a write to the same word therefore
    // already sees the new value.
    assign s_HRDATA    = (state_q == SL_DATA && !write_q && legal_q) ? mem_rdata : 32'd0;
    assign s_HREADYOUT = hreadyout_q;
    assign s_HRESP     = hresp_q;
    assign s_dbg_state = state_q;

endmodule
